alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU with valid/ready handshakes on both sides.
// Eight opcodes (zero, pass A, add, sub, mul, and, or, xor). Non-multiply
// operations complete in one edge; multiply is an iterative shift-add taking
// WIDTH edges in state MUL.
// Handshake: an operation is accepted on a rising edge with in_valid && in_ready;
// a result is consumed on a rising edge with out_valid && out_ready. A consumed
// result and a new accept may share the same edge, so issue is bubble-free.
// Optional build macro: ALU_SAT_EN selects saturating add/sub/mul results.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             x_bit,
    output logic             z_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_PASS = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FSM state is kept as a named enum so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     result_q;
    logic                 x_q;
    logic                 z_q;

    logic                 accept;
    logic                 last_step;
    logic [WIDTH:0]       add_ext;
    logic [WIDTH:0]       sub_ext;
    logic [WIDTH-1:0]     op_res;
    logic                 op_x;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mul_res;
    logic                 mul_x;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);
    assign last_step = (cnt == CW'(1));
    assign result    = result_q;
    assign x_bit     = x_q;
    assign z_bit     = z_q;

    assign add_ext  = {1'b0, a} + {1'b0, b};
    assign sub_ext  = {1'b0, a} - {1'b0, b};
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_x    = (acc_step[2*WIDTH-1:WIDTH] != '0);

    // Single-edge operations, evaluated from the operands presented at accept.
    always_comb begin
        op_res = '0;
        op_x   = 1'b0;
        case (opcode)
            OP_ZERO: op_res = '0;
            OP_PASS: op_res = a;
            OP_ADD: begin
                op_x = add_ext[WIDTH];
`ifdef ALU_SAT_EN
                op_res = add_ext[WIDTH] ? '1 : add_ext[WIDTH-1:0];
`else
                op_res = add_ext[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // Borrow out of the extended subtraction means a < b unsigned.
                op_x = sub_ext[WIDTH];
`ifdef ALU_SAT_EN
                op_res = sub_ext[WIDTH] ? '0 : sub_ext[WIDTH-1:0];
`else
                op_res = sub_ext[WIDTH-1:0];
`endif
            end
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            default: op_res = '0;
        endcase
    end

    // Final multiply result taken from the accumulator after the last add.
    always_comb begin
`ifdef ALU_SAT_EN
        mul_res = mul_x ? '1 : acc_step[WIDTH-1:0];
`else
        mul_res = acc_step[WIDTH-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept has priority, since it is only possible in IDLE
    // or in DONE while the current result is being consumed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (opcode == OP_MUL) ? MUL : DONE;
            end
            MUL: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_next = (opcode == OP_MUL) ? MUL : DONE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate the multiplier, hold results in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            result_q <= '0;
            x_q      <= 1'b0;
            z_q      <= 1'b0;
        end else if (accept) begin
            if (opcode == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= CW'(WIDTH);
            end else begin
                result_q <= op_res;
                x_q      <= op_x;
                z_q      <= (op_res == '0);
            end
        end else if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last_step) begin
                result_q <= mul_res;
                x_q      <= mul_x;
                z_q      <= (mul_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=16.
// Expected values are hand-computed; ALU_SAT_EN selects the saturating set.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         x_bit;
    logic         z_bit;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_n;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .x_bit     (x_bit),
        .z_bit     (z_bit),
        .busy      (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, confirm it can be taken, and step past its accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input string tag);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        #1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] r,
                              input logic x, input logic z);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " result"},    64'(result),    64'(r));
        chk({tag, " x_bit"},     64'(x_bit),     64'(x));
        chk({tag, " z_bit"},     64'(z_bit),     64'(z));
    endtask

    initial begin
        // Reset.
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        opcode    = 3'd0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst in_ready",  64'(in_ready),  64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst result",    64'(result),    64'd0);
        chk("rst x_bit",     64'(x_bit),     64'd0);
        chk("rst z_bit",     64'(z_bit),     64'd0);
        chk("rst busy",      64'(busy),      64'd0);

        // add 0xFFFF + 1: carry out.
        issue(3'd2, 16'hFFFF, 16'h0001, "add_ovf");
`ifdef ALU_SAT_EN
        expect_res("add_ovf", 16'hFFFF, 1'b1, 1'b0);
`else
        expect_res("add_ovf", 16'h0000, 1'b1, 1'b1);
`endif
        tick();
        chk("add_ovf consumed", 64'(out_valid), 64'd0);

        // sub 3 - 5: borrow.
        issue(3'd3, 16'd3, 16'd5, "sub_brw");
`ifdef ALU_SAT_EN
        expect_res("sub_brw", 16'h0000, 1'b1, 1'b1);
`else
        expect_res("sub_brw", 16'hFFFE, 1'b1, 1'b0);
`endif
        // sub 5 - 5 issued back-to-back while the previous result is consumed.
        issue(3'd3, 16'd5, 16'd5, "sub_eq");
        expect_res("sub_eq", 16'h0000, 1'b0, 1'b1);

        // Back-to-back logic ops, pass and zero, one result per edge.
        issue(3'd5, 16'hF0F0, 16'h0FF0, "and");
        expect_res("and", 16'h00F0, 1'b0, 1'b0);
        issue(3'd6, 16'hF0F0, 16'h0FF0, "or");
        expect_res("or", 16'hFFF0, 1'b0, 1'b0);
        issue(3'd7, 16'hF0F0, 16'h0FF0, "xor");
        expect_res("xor", 16'hFF00, 1'b0, 1'b0);
        issue(3'd1, 16'h1234, 16'hABCD, "pass");
        expect_res("pass", 16'h1234, 1'b0, 1'b0);
        issue(3'd0, 16'h5555, 16'hAAAA, "zero");
        expect_res("zero", 16'h0000, 1'b0, 1'b1);
        tick();
        chk("zero consumed", 64'(out_valid), 64'd0);

        // mul 300 * 200 = 60000: latency and busy window.
        issue(3'd4, 16'd300, 16'd200, "mul1");
        chk("mul1 busy",     64'(busy),      64'd1);
        chk("mul1 in_ready", 64'(in_ready),  64'd0);
        chk("mul1 early",    64'(out_valid), 64'd0);
        lat    = 1;
        busy_n = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_n++;
            if (!out_valid) chk("mul1 in_ready low", 64'(in_ready), 64'd0);
        end
        chk("mul1 latency",  64'(lat),    64'd17);
        chk("mul1 busy_cyc", 64'(busy_n), 64'd16);
        chk("mul1 busy end", 64'(busy),   64'd0);
        expect_res("mul1", 16'hEA60, 1'b0, 1'b0);
        tick();

        // mul 0x0100 * 0x0100 = 0x10000: high half nonzero.
        issue(3'd4, 16'h0100, 16'h0100, "mul2");
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("mul2 latency", 64'(lat), 64'd17);
`ifdef ALU_SAT_EN
        expect_res("mul2", 16'hFFFF, 1'b1, 1'b0);
`else
        expect_res("mul2", 16'h0000, 1'b1, 1'b1);
`endif
        tick();

        // Backpressure: add 7 + 8 held while the consumer stalls.
        out_ready = 1'b0;
        issue(3'd2, 16'd7, 16'd8, "bp");
        expect_res("bp", 16'h000F, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            opcode   = 3'd2;
            a        = 16'($urandom_range(0, 16'hFFFF));
            b        = 16'($urandom_range(1, 16'hFFFF));
            #1;
            chk("bp in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp hold",      64'(result),    64'h000F);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp consumed", 64'(out_valid), 64'd0);

        // Reset in the 8th MUL cycle abandons the multiply.
        issue(3'd4, 16'd123, 16'd456, "mul_rst");
        repeat (7) tick();
        chk("mul_rst still busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mul_rst out_valid", 64'(out_valid), 64'd0);
        chk("mul_rst busy",      64'(busy),      64'd0);
        chk("mul_rst in_ready",  64'(in_ready),  64'd1);
        chk("mul_rst result",    64'(result),    64'd0);
        chk("mul_rst x_bit",     64'(x_bit),     64'd0);
        chk("mul_rst z_bit",     64'(z_bit),     64'd0);
        issue(3'd2, 16'd1, 16'd1, "post_rst");
        expect_res("post_rst", 16'h0002, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
